uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 27000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries, power of two, minimum 2.
REQ-007 SHALL have port clock, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-009 SHALL have port tx_valid, input, 1 bit, meaning data_in holds a word to send.
REQ-010 SHALL have port data_in, input, DATA_BITS bits, meaning the payload, sent LSB first.
REQ-011 SHALL have port tx_ready, output, 1 bit, meaning the block can accept a word this cycle.
REQ-012 SHALL have port tx, output, 1 bit, meaning the serial line, idle high.
REQ-013 SHALL have port tx_busy, output, 1 bit, meaning a frame is on the line.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, meaning words queued and not yet started.

Function
REQ-015 SHALL define BAUD_TICKS = CLOCK_FREQ/BAUDRATE (integer division); every bit cell SHALL last exactly BAUD_TICKS clocks.
REQ-016 SHALL accept a word on a rising edge where tx_valid && tx_ready; tx_valid while tx_ready is low SHALL be ignored, with no loss of queued data.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY==0.
REQ-018 Frame SHALL be: start 0, DATA_BITS data LSB first, optional parity, STOP_BITS ones; length 1+DATA_BITS+(PARITY!=0)+STOP_BITS cells.
REQ-019 Parity bit SHALL make the count of ones over data plus parity odd (PARITY=1) or even (PARITY=2).
REQ-020 IDLE with a non-empty queue SHALL pop the head word and enter START; when accepted into an empty idle block, tx SHALL go low exactly 2 clocks after the accepting edge.
REQ-021 At the end of the last stop cell with the queue non-empty, SHALL pop and enter START on the next cycle with no idle cell inserted; with the queue empty it SHALL return to IDLE.
REQ-022 tx_busy SHALL be high from the pop cycle through the last stop cell, and low in IDLE.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-024 tx_ready SHALL be low exactly when the queue is full; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 The word in flight SHALL be latched at pop, so later changes to data_in do not affect the frame.

Reset
REQ-026 While reset is high at a clock edge, the next state SHALL be: tx=1, tx_busy=0, tx_ready=1, fifo_count=0, state IDLE, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame, drive tx high from the next cycle, and discard all queued words.

Configuration
REQ-028 Macro UART_TX_FIFO_EN SHALL select buffering: defined, the queue SHALL be a FIFO_DEPTH-entry FIFO.
REQ-029 Without UART_TX_FIFO_EN, the queue SHALL be a single holding register: FIFO_DEPTH is ignored, fifo_count saturates at 1, and tx_ready=0 while the register is occupied.

Verification (CLOCK_FREQ=1600, BAUDRATE=100, so BAUD_TICKS=16)
REQ-030 8N1, push 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each 16 clocks; tx_busy high 160 clocks; tx low 2 clocks after accept.
REQ-031 DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x41 -> parity cell 0; frame 11 cells = 176 clocks.
REQ-032 DATA_BITS=8, PARITY=1, push 0xFF -> parity cell 1; same with PARITY=2 -> parity cell 0.
REQ-033 UART_TX_FIFO_EN defined, FIFO_DEPTH=4, tx_valid held high with 0x01..0x06 -> fifo_count peaks at 4, tx_ready drops, no word lost, six frames back-to-back with no high gap between stop and next start.
REQ-034 Reset pulsed during data bit 3 with 2 words queued -> next cycle tx=1, tx_busy=0, fifo_count=0, tx_ready=1; no further frames.
REQ-035 UART_TX_FIFO_EN undefined, push 0xA5, 0x3C, 0x0F -> tx_ready low while holding register is full, all three frames sent in order.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- parameterised UART transmitter with a small transmit queue.
//
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS ones.
// Every bit cell lasts BAUD_TICKS = CLOCK_FREQ/BAUDRATE clocks.
//
// Build option: define UART_TX_FIFO_EN to get a FIFO_DEPTH-entry FIFO in
// front of the shifter. Without it the queue is a single holding register,
// fifo_count saturates at 1 and FIFO_DEPTH only sizes the fifo_count port.
//
// Timing: the line outputs (tx, tx_busy) are registered from the FSM state,
// so they trail the state by one clock. A word accepted into an idle block
// is popped on the next edge and appears as a start bit one edge later.
module uart_tx_cfg #(
    parameter int CLOCK_FREQ = 27000000,
    parameter int BAUDRATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            tx_valid,
    input  logic [DATA_BITS-1:0]            data_in,
    output logic                            tx_ready,
    output logic                            tx,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int BAUD_TICKS = CLOCK_FREQ / BAUDRATE;
    localparam int TW         = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int BW         = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 r_state;
    logic [TW-1:0]          r_tick;
    logic [BW-1:0]          r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_busy;
    logic [CW-1:0]          r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_cell_end;
    logic                   w_frame_end;
    logic                   w_line;
    logic [DATA_BITS-1:0]   w_head;

    assign w_empty     = (r_count == '0);
    assign w_push      = tx_valid && !w_full;
    assign w_cell_end  = (r_tick == TW'(BAUD_TICKS - 1));
    assign w_frame_end = (r_state == ST_STOP) && w_cell_end &&
                         (r_bit == BW'(STOP_BITS - 1));
    // Pop either from idle or exactly at the end of the last stop cell, so
    // queued words go out back-to-back with no idle cell in between.
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_frame_end);

    assign tx_ready    = !w_full;
    assign fifo_count  = r_count;
    assign tx          = r_tx;
    assign tx_busy     = r_busy;

`ifdef UART_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_head = r_mem[r_rd_ptr];

    // FIFO storage: written on push, no reset needed for the data itself
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= data_in;
    end

    // FIFO pointers; power-of-two depth makes the wrap a plain overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
`else
    logic [DATA_BITS-1:0]   r_hold;

    assign w_full = !w_empty;
    assign w_head = r_hold;

    // single holding register; only written while empty
    always_ff @(posedge clock) begin
        if (w_push)
            r_hold <= data_in;
    end
`endif

    // occupancy: simultaneous push and pop leaves it unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // value the line should carry for the current FSM state
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            ST_START:  w_line = 1'b0;
            ST_DATA:   w_line = r_shift[0];
            ST_PARITY: w_line = r_par;
            default:   w_line = 1'b1;
        endcase
    end

    // frame FSM with bit-cell timer; line outputs registered one clock behind
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_tx   <= w_line;
            r_busy <= (r_state != ST_IDLE);
            if (r_state == ST_IDLE) begin
                if (w_pop) begin
                    // latch the word so data_in may change freely afterwards
                    r_shift <= w_head;
                    r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
                    r_tick  <= '0;
                    r_bit   <= '0;
                    r_state <= ST_START;
                end
            end else if (!w_cell_end) begin
                r_tick <= r_tick + 1'b1;
            end else begin
                r_tick <= '0;
                case (r_state)
                    ST_START: begin
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_shift <= r_shift >> 1;
                        if (r_bit == BW'(DATA_BITS - 1)) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        r_bit   <= '0;
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (r_bit == BW'(STOP_BITS - 1)) begin
                            r_bit <= '0;
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
                                r_state <= ST_START;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
